// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle sequencing controller.
// Optional branch-with-link sequencing is enabled by defining MC_BL_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
`ifdef MC_BL_EN
    ,
    S_LINK     = 4'd10
`endif
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    SRCB_WDATA = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_FOUR  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_RDATA  = 2'b01,
    RES_ALURES = 2'b10
  } result_src_e;

  // Ungated controls straight from the state; the top applies CondEx/MemReady.
  typedef struct packed {
    logic        next_pc;
    logic        ir_write;
    logic        branch;
    logic        reg_w;
    logic        mem_w;
    logic        adr_src;
    logic        alu_src_a;
    alu_src_b_e  alu_src_b;
    result_src_e result_src;
    logic        alu_op;
    logic        flag_wen;
    logic        link_write;
  } raw_ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps the controller state onto the raw control bundle.
// The LINK state decode is present only when MC_BL_EN is defined.
module mc_outdec
  import mc_pkg::*;
(
  input  state_e    state,
  output raw_ctrl_t raw
);

  always_comb begin
    // NOTE: the whole bundle is defaulted first so no path through the case infers a latch.
    raw = '0;
    case (state)
      S_FETCH: begin
        raw.adr_src    = 1'b0;
        raw.alu_src_a  = 1'b1;
        raw.alu_src_b  = SRCB_FOUR;
        raw.result_src = RES_ALURES;
        raw.ir_write   = 1'b1;
        raw.next_pc    = 1'b1;
      end
      S_DECODE: begin
        raw.alu_src_a  = 1'b1;
        raw.alu_src_b  = SRCB_FOUR;
        raw.result_src = RES_ALURES;
      end
      S_MEMADR: begin
        raw.alu_src_a = 1'b0;
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = 1'b0;
      end
      S_MEMRD: begin
        raw.adr_src = 1'b1;
      end
      S_MEMWB: begin
        raw.result_src = RES_RDATA;
        raw.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        raw.adr_src = 1'b1;
        raw.mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        raw.alu_src_a = 1'b0;
        raw.alu_src_b = SRCB_WDATA;
        raw.alu_op    = 1'b1;
        raw.flag_wen  = 1'b1;
      end
      S_EXECUTEI: begin
        raw.alu_src_a = 1'b0;
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = 1'b1;
        raw.flag_wen  = 1'b1;
      end
      S_ALUWB: begin
        raw.result_src = RES_ALUOUT;
        raw.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        raw.alu_src_a  = 1'b0;
        raw.alu_src_b  = SRCB_IMM;
        raw.result_src = RES_ALURES;
        raw.branch     = 1'b1;
      end
`ifdef MC_BL_EN
      // ALUOut still holds PC+4 computed during DECODE.
      S_LINK: begin
        raw.result_src = RES_ALUOUT;
        raw.reg_w      = 1'b1;
        raw.link_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencing controller: state register, next-state logic and write gating.
// Define MC_BL_EN to add the LINK state for branch-with-link.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       FlagWEn,
  output logic       LinkWrite,
  output logic       IllegalOp,
  output logic       InstrDone
);

  state_e    state_q, state_d;
  raw_ctrl_t raw;
  logic      live;
  logic      illegal;
  logic      done_raw;
  logic      unused_bits;

  mc_outdec u_outdec (
    .state (state_q),
    .raw   (raw)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM: state_d = S_MEMADR;
          OP_DP:  state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
`ifdef MC_BL_EN
          OP_BR:  state_d = Funct[4] ? S_LINK : S_BRANCH;
`else
          OP_BR:  state_d = S_BRANCH;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    if (MemReady) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef MC_BL_EN
      S_LINK:     state_d = S_BRANCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    done_raw = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: done_raw = 1'b1;
      S_MEMWR:                    done_raw = MemReady;
      S_DECODE:                   done_raw = (Op == OP_ILL);
      default: ;
    endcase
  end

  // Reset is asynchronous, so enables are also masked combinationally while it is held.
  assign live    = ~rst;
  assign illegal = (state_q == S_DECODE) && (Op == OP_ILL);

  assign AdrSrc    = raw.adr_src;
  assign ALUSrcA   = raw.alu_src_a;
  assign ALUSrcB   = raw.alu_src_b;
  assign ResultSrc = raw.result_src;
  assign ALUOp     = raw.alu_op;

  assign IRWrite   = live & raw.ir_write & MemReady;
  assign PCWrite   = live & ((raw.next_pc & MemReady) | (raw.branch & CondEx));
  assign RegWrite  = live & raw.reg_w & CondEx;
  assign MemWrite  = live & raw.mem_w & CondEx;
  assign FlagWEn   = live & raw.flag_wen;
  assign IllegalOp = live & illegal;
  assign InstrDone = live & done_raw;

`ifdef MC_BL_EN
  assign LinkWrite   = live & raw.link_write;
  assign unused_bits = ^Funct[3:1];
`else
  assign LinkWrite   = 1'b0;
  assign unused_bits = ^{Funct[4:1], raw.link_write};
`endif

endmodule

// File: doc/mc_controller.md
# mc_controller

Main sequencing controller for the multicycle variant of the processor. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory-ready handshake and drives the datapath mux selects and write enables. Architectural writes are gated with the condition result (`CondEx`) from the condition logic, so unexecuted conditional instructions still consume their cycles but change no state.

## Interface
Parameters: none.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Op` in 2: instruction bits [27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `Funct` in 6: instruction bits [25:20]; [5] is I (immediate), [4] is L (branch link), [0] is L/S (load).
- `CondEx` in 1: condition passed; valid from DECODE onward.
- `MemReady` in 1: memory completes the current access this cycle.
- `IRWrite` out 1: load instruction register.
- `AdrSrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ALUSrcA` out 1: 0 = register A, 1 = PC.
- `ALUSrcB` out 2: 00 = WriteData register, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = read data, 10 = ALUResult.
- `ALUOp` out 1: 1 = ALU decoder uses `Funct`; 0 = add.
- `PCWrite` out 1: load PC.
- `RegWrite` out 1: register file write.
- `MemWrite` out 1: data memory write.
- `FlagWEn` out 1: flag-update window; the condition logic combines it with the S bit.
- `LinkWrite` out 1: force register-file destination to R14.
- `IllegalOp` out 1: one-cycle pulse on an `Op` = 11 decode.
- `InstrDone` out 1: one-cycle pulse on the last cycle of each instruction.

## Operation
States, with the asserted raw controls and the next state:
- FETCH: `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10. If `MemReady`, assert `IRWrite` and NextPC, then go to DECODE; otherwise hold in FETCH.
- DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10. Next state by `Op`:
  - 01 goes to MEMADR.
  - 00 goes to EXECUTEI if `Funct[5]`, else EXECUTER.
  - 10 goes to BRANCH.
  - 11 pulses `IllegalOp` and `InstrDone`, then goes to FETCH.
- MEMADR: `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=0. Goes to MEMRD if `Funct[0]`, else MEMWR.
- MEMRD: `AdrSrc`=1. Holds until `MemReady`, then goes to MEMWB.
- MEMWB: `ResultSrc`=01, RegW. Goes to FETCH.
- MEMWR: `AdrSrc`=1, MemW held every cycle until `MemReady`, then goes to FETCH.
- EXECUTER: `ALUSrcA`=0, `ALUSrcB`=00, `ALUOp`=1, `FlagWEn`=1. Goes to ALUWB.
- EXECUTEI: as EXECUTER but `ALUSrcB`=01. Goes to ALUWB.
- ALUWB: `ResultSrc`=00, RegW. Goes to FETCH.
- BRANCH: `ALUSrcA`=0, `ALUSrcB`=01, `ResultSrc`=10, Branch. Goes to FETCH.

Write gating:
- `PCWrite` = NextPC | (Branch & `CondEx`).
- `RegWrite` = RegW & `CondEx`.
- `MemWrite` = MemW & `CondEx`.
- A failed condition never shortens the sequence.

`InstrDone` is asserted in MEMWB, ALUWB, BRANCH, the DECODE illegal path, and the MEMWR cycle in which `MemReady` is high.

## Timing
- All outputs are decoded from the registered state, plus `MemReady`, `CondEx` and `Op` where listed above.
- While `rst` is high:
  - State is FETCH.
  - `IRWrite`, `PCWrite`, `RegWrite`, `MemWrite`, `FlagWEn`, `LinkWrite`, `IllegalOp` and `InstrDone` are forced to 0.
  - Mux selects take their FETCH values.
- Reset asserted mid-instruction abandons that instruction; no partial write is issued after the reset edge.
- Cycle counts with `MemReady` held high:
  - LDR: 5.
  - STR: 4.
  - Data-processing: 4.
  - B: 3.
  - BL: 4, only when `MC_BL_EN` is defined.
- Each cycle with `MemReady` low in FETCH, MEMRD or MEMWR adds one cycle. No other state looks at `MemReady`.
- `MemReady` high outside a memory state is ignored.
- `CondEx` is sampled combinationally in every gated state.

## Configuration
- `MC_BL_EN` defined:
  - DECODE with `Op`=10 and `Funct[4]`=1 goes to LINK instead of BRANCH.
  - LINK: `ResultSrc`=00 (ALUOut holds PC+4 from DECODE), RegW, `LinkWrite`=1. Goes to BRANCH.
- `MC_BL_EN` not defined: the LINK state does not exist, `LinkWrite` is tied to 0, and `Funct[4]` is ignored for branches.

## Structure
- `mc_pkg` holds:
  - the state enum;
  - `Op` code constants;
  - `ALUSrcB` and `ResultSrc` encodings;
  - a packed raw-control struct containing NextPC, Branch, RegW, MemW and the mux selects.
- Sub-module `mc_outdec`: purely combinational mapping from state to raw-control struct. The top level holds the state register, next-state logic and `CondEx`/`MemReady` gating.

## Test plan
- Reset held 3 cycles, then released, with `MemReady`=1 and `Op`=00, `Funct[5]`=0: state sequence FETCH, DECODE, EXECUTER, ALUWB. `RegWrite`=1 only in ALUWB. `InstrDone` pulses in cycle 4.
- LDR (`Op`=01, `Funct[0]`=1) with `MemReady` low for 2 cycles in MEMRD: 7 cycles total; `RegWrite` only in MEMWB with `ResultSrc`=01.
- STR with `CondEx`=0: `MemWrite` stays 0 in MEMWR for 4 cycles; `PCWrite` pulses only in FETCH.
- B with `CondEx`=1: `PCWrite`=1 in BRANCH with `ResultSrc`=10. With `CondEx`=0: `PCWrite`=0 in BRANCH.
- `Op`=11: `IllegalOp`=1 for exactly one cycle in DECODE, then FETCH. Reset asserted during MEMWR: `MemWrite` drops to 0 in the same cycle.
- With `MC_BL_EN` defined, BL (`Funct[4]`=1): LINK asserts `RegWrite`=1 and `LinkWrite`=1, then BRANCH follows; 4 cycles total.
